// File: rtl/gsram_ctrl_pkg.sv
// Shared types and helpers for the 512x32 SRAM request controller.
// Holds default geometry, response depth, FSM states and byte-mask expansion.
package gsram_ctrl_pkg;

   localparam int ABITS_DEF = 9;
   localparam int DBITS_DEF = 32;
   localparam int RSP_DEPTH = 2;
   localparam int MAX_DBITS = 1024;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   // Bit i of the mask follows byte enable i/8; callers truncate to width.
   function automatic logic [MAX_DBITS-1:0] be_to_mask(
      input logic [MAX_DBITS/8-1:0] be
   );
      logic [MAX_DBITS-1:0] m;
      for (int i = 0; i < MAX_DBITS; i++) begin
         m[i] = be[i/8];
      end
      return m;
   endfunction

endpackage

// File: rtl/gsram_rsp_fifo.sv
// Two-entry read-response buffer between the SRAM read port and the consumer.
// Head entry stays stable until popped; reset empties it.
module gsram_rsp_fifo
   import gsram_ctrl_pkg::*;
#(
   parameter int DBITS = DBITS_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             i_push,
   input  logic [DBITS-1:0] i_data,
   input  logic             i_pop,
   output logic [DBITS-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(RSP_DEPTH);

   logic [DBITS-1:0] r_mem [RSP_DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_cnt;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_cnt == FULL_CNT);
   assign o_empty = (r_cnt == '0);
   assign o_data  = r_mem[r_rptr];
   assign w_push  = i_push & (~o_full | i_pop);
   assign w_pop   = i_pop & ~o_empty;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage write; entries need no reset since occupancy gates the head.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   // Credits upstream should make a push into a full buffer impossible.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert (!(i_push && o_full && !i_pop))
            else $error("rsp fifo overflow");
      end
   end

endmodule

// File: rtl/gsram_512x32_ctrl.sv
// Request-side controller driving both ports of the 512x32 dual-port SRAM.
// Zero-fills the array after reset, then serves write and read streams.
module gsram_512x32_ctrl
   import gsram_ctrl_pkg::*;
#(
   parameter int ABITS     = ABITS_DEF,
   parameter int DBITS     = DBITS_DEF,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [ABITS-1:0]   wr_addr,
   input  logic [DBITS-1:0]   wr_data,
   input  logic [DBITS/8-1:0] wr_be,
   input  logic               rd_req_valid,
   output logic               rd_req_ready,
   input  logic [ABITS-1:0]   rd_req_addr,
   output logic               rd_rsp_valid,
   input  logic               rd_rsp_ready,
   output logic [DBITS-1:0]   rd_rsp_data,
   output logic               init_done,
   output logic [ABITS-1:0]   mem_a0,
   output logic [DBITS-1:0]   mem_d0,
   output logic               mem_we0,
   output logic [DBITS-1:0]   mem_wem0,
   output logic               mem_ce0,
   output logic [ABITS-1:0]   mem_a1,
   output logic [DBITS-1:0]   mem_d1,
   output logic               mem_we1,
   output logic [DBITS-1:0]   mem_wem1,
   output logic               mem_ce1,
   input  logic [DBITS-1:0]   mem_q1
);

   localparam logic [1:0] CRED_MAX = 2'(RSP_DEPTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ABITS-1:0] r_init_cnt;
   logic [1:0]       r_cnt;
   logic             r_rd_pend;
   logic             w_run;
   logic             w_wr_fire;
   logic             w_rd_fire;
   logic             w_pop;
   logic             w_collide;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [DBITS-1:0] w_wmask;

   // Outputs are held quiet during the reset cycle itself.
   assign w_run     = (r_state == RUN) & ~RST;
   assign init_done = w_run;
   assign wr_ready  = w_run;
   assign w_wr_fire = wr_valid & w_run;
   assign w_wmask   =
      DBITS'(be_to_mask((MAX_DBITS/8)'(wr_be)));

   // A same-address write always wins; the read retries later.
   assign w_collide = w_wr_fire & rd_req_valid
                    & (wr_addr == rd_req_addr);

   assign rd_rsp_valid = ~w_fifo_empty & ~RST;
   assign w_pop        = rd_rsp_valid & rd_rsp_ready;
   // Combinational path from rd_rsp_ready keeps full throughput.
   assign rd_req_ready = w_run & ~w_collide
                       & ((r_cnt != CRED_MAX) | w_pop);
   assign w_rd_fire    = rd_req_valid & rd_req_ready;

   assign mem_ce1  = w_rd_fire;
   assign mem_a1   = rd_req_addr;
   assign mem_d1   = '0;
   assign mem_we1  = 1'b0;
   assign mem_wem1 = '0;

   // State register and zero-fill address counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= INIT_ZERO ? INIT : RUN;
         r_init_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == INIT) r_init_cnt <= r_init_cnt + 1'b1;
      end
   end

   // Next state and write-port drive for zero-fill or user writes.
   always_comb begin
      w_state_nxt = r_state;
      mem_ce0     = 1'b0;
      mem_we0     = 1'b0;
      mem_a0      = '0;
      mem_d0      = '0;
      mem_wem0    = '0;
      unique case (r_state)
         INIT: begin
            if (!RST) begin
               mem_ce0  = 1'b1;
               mem_we0  = 1'b1;
               mem_a0   = r_init_cnt;
               mem_wem0 = '1;
            end
            if (r_init_cnt == '1) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_wr_fire) begin
               mem_ce0  = 1'b1;
               mem_we0  = 1'b1;
               mem_a0   = wr_addr;
               mem_d0   = wr_data;
               mem_wem0 = w_wmask;
            end
         end
         default: w_state_nxt = r_state;
      endcase
   end

   // Credits count buffered entries plus the read in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt     <= '0;
         r_rd_pend <= 1'b0;
      end else begin
         r_rd_pend <= w_rd_fire;
         unique case ({w_rd_fire, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   gsram_rsp_fifo #(
      .DBITS (DBITS)
   ) u_rsp_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .i_push  (r_rd_pend),
      .i_data  (mem_q1),
      .i_pop   (w_pop),
      .o_data  (rd_rsp_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

endmodule

// File: tb/tb_gsram_512x32_ctrl.sv
// Bench for gsram_512x32_ctrl with a behavioural 512x32 SRAM model.
// Directed vectors plus hand-written init, collision, backpressure, reset.
module tb_gsram_512x32_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        wr_valid;
   logic        wr_ready;
   logic [8:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_req_valid;
   logic        rd_req_ready;
   logic [8:0]  rd_req_addr;
   logic        rd_rsp_valid;
   logic        rd_rsp_ready;
   logic [31:0] rd_rsp_data;
   logic        init_done;
   logic [8:0]  mem_a0;
   logic [31:0] mem_d0;
   logic        mem_we0;
   logic [31:0] mem_wem0;
   logic        mem_ce0;
   logic [8:0]  mem_a1;
   logic [31:0] mem_d1;
   logic        mem_we1;
   logic [31:0] mem_wem1;
   logic        mem_ce1;
   logic [31:0] mem_q1;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   gsram_512x32_ctrl dut (
      .CLK          (CLK),
      .RST          (RST),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_req_addr  (rd_req_addr),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .rd_rsp_data  (rd_rsp_data),
      .init_done    (init_done),
      .mem_a0       (mem_a0),
      .mem_d0       (mem_d0),
      .mem_we0      (mem_we0),
      .mem_wem0     (mem_wem0),
      .mem_ce0      (mem_ce0),
      .mem_a1       (mem_a1),
      .mem_d1       (mem_d1),
      .mem_we1      (mem_we1),
      .mem_wem1     (mem_wem1),
      .mem_ce1      (mem_ce1),
      .mem_q1       (mem_q1)
   );

   // SRAM model; contents scrambled while reset is held.
   logic [31:0] mem [512];
   always @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 512; i++) mem[i] <= $urandom;
      end else if (mem_ce0 && mem_we0) begin
         mem[mem_a0] <= (mem[mem_a0] & ~mem_wem0) | (mem_d0 & mem_wem0);
      end
      if (mem_ce1) mem_q1 <= mem[mem_a1];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_read(input logic [8:0] a, input logic [31:0] exp,
                          input string nm);
      int  t;
      bit  ok;
      rd_req_valid = 1'b1;
      rd_req_addr  = a;
      ok = 1'b0;
      for (t = 0; t < 10; t++) begin
         @(negedge CLK);
         if (rd_req_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({nm, " accepted"}, 64'(ok), 64'd1);
      tick();
      rd_req_valid = 1'b0;
      ok = 1'b0;
      for (t = 1; t < 10; t++) begin
         @(negedge CLK);
         if (rd_rsp_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({nm, " latency"}, 64'(t), 64'd2);
      check({nm, " data"}, 64'(rd_rsp_data), 64'(exp));
      tick();
   endtask

   typedef struct {
      logic [8:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t        vt [6];
   logic [8:0]  ba [5];
   logic [31:0] bx [5];
   logic [31:0] rsp [5];
   int          acc_c [5];

   initial begin
      int e;
      int np;
      int idx;
      int got;
      int c;

      vt[0] = '{9'h1FF, 32'h0BAD_F00D, 4'b0000, 32'h0000_0000};
      vt[1] = '{9'h1A3, 32'hDEAD_BEEF, 4'b0101, 32'h00AD_00EF};
      vt[2] = '{9'h005, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
      vt[3] = '{9'h005, 32'h1122_3344, 4'b1000, 32'h11FE_F00D};
      vt[4] = '{9'h000, 32'hA5A5_A5A5, 4'b0010, 32'h0000_A500};
      vt[5] = '{9'h100, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000};

      ba[0] = 9'h1A3; bx[0] = 32'h00AD_00EF;
      ba[1] = 9'h005; bx[1] = 32'h11FE_F00D;
      ba[2] = 9'h000; bx[2] = 32'h0000_A500;
      ba[3] = 9'h010; bx[3] = 32'h1234_5678;
      ba[4] = 9'h1FF; bx[4] = 32'h0000_0000;

      RST          = 1'b1;
      wr_valid     = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      wr_be        = '0;
      rd_req_valid = 1'b0;
      rd_req_addr  = '0;
      rd_rsp_ready = 1'b1;

      repeat (2) tick();
      @(negedge CLK);
      check("reset outputs",
            64'({wr_ready, rd_req_ready, rd_rsp_valid, init_done,
                 mem_ce0, mem_ce1, mem_we0}), 64'd0);
      tick();
      RST = 1'b0;

      // Requests held during INIT must be ignored.
      wr_valid     = 1'b1;
      wr_addr      = 9'h1A3;
      wr_data      = 32'h5555_AAAA;
      wr_be        = 4'hF;
      rd_req_valid = 1'b1;
      rd_req_addr  = 9'h033;
      e  = 0;
      np = 0;
      for (int k = 1; k <= 513; k++) begin
         @(negedge CLK);
         if (k <= 512) begin
            if (mem_we0 && mem_ce0) np++;
            if (!(mem_we0 && mem_ce0 && mem_a0 == 9'(k - 1)
                  && mem_d0 == 32'd0 && mem_wem0 == 32'hFFFF_FFFF
                  && !init_done && !wr_ready && !rd_req_ready
                  && !mem_ce1))
               e++;
         end else begin
            check("init_done cycle 513", 64'(init_done), 64'd1);
         end
         tick();
         if (k == 512) begin
            wr_valid     = 1'b0;
            rd_req_valid = 1'b0;
         end
      end
      check("init sequence errors", 64'(e), 64'd0);
      check("init write pulses", 64'(np), 64'd512);

      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1;
         wr_addr  = vt[i].a;
         wr_data  = vt[i].d;
         wr_be    = vt[i].be;
         @(negedge CLK);
         check($sformatf("vec%0d wr_ready", i), 64'(wr_ready), 64'd1);
         tick();
         wr_valid = 1'b0;
         do_read(vt[i].a, vt[i].exp, $sformatf("vec%0d", i));
      end

      // Same-cycle write and read to one address.
      wr_valid     = 1'b1;
      wr_addr      = 9'h010;
      wr_data      = 32'h1234_5678;
      wr_be        = 4'hF;
      rd_req_valid = 1'b1;
      rd_req_addr  = 9'h010;
      @(negedge CLK);
      check("collide rd_req_ready", 64'(rd_req_ready), 64'd0);
      check("collide mem_ce1", 64'(mem_ce1), 64'd0);
      tick();
      wr_valid = 1'b0;
      @(negedge CLK);
      check("collide retry ready", 64'(rd_req_ready), 64'd1);
      tick();
      rd_req_valid = 1'b0;
      for (c = 1; c < 10; c++) begin
         @(negedge CLK);
         if (rd_rsp_valid) break;
         tick();
      end
      check("collide latency", 64'(c), 64'd2);
      check("collide data", 64'(rd_rsp_data), 64'h1234_5678);
      tick();

      // Five back-to-back reads against a stalled consumer.
      rd_rsp_ready = 1'b0;
      idx = 0;
      got = 0;
      for (int k = 0; k < 6; k++) begin
         rd_req_valid = (idx < 5);
         rd_req_addr  = ba[(idx < 5) ? idx : 0];
         @(negedge CLK);
         if (rd_req_valid && rd_req_ready) idx++;
         tick();
      end
      check("bp accepted while stalled", 64'(idx), 64'd2);
      @(negedge CLK);
      check("bp ready held low", 64'(rd_req_ready), 64'd0);
      check("bp rsp valid", 64'(rd_rsp_valid), 64'd1);
      tick();
      rd_rsp_ready = 1'b1;
      for (int k = 0; k < 20 && (idx < 5 || got < 5); k++) begin
         rd_req_valid = (idx < 5);
         rd_req_addr  = ba[(idx < 5) ? idx : 0];
         @(negedge CLK);
         if (rd_rsp_valid && got < 5) begin
            rsp[got] = rd_rsp_data;
            got++;
         end
         if (rd_req_valid && rd_req_ready) begin
            acc_c[idx] = k;
            idx++;
         end
         tick();
      end
      rd_req_valid = 1'b0;
      check("bp total accepted", 64'(idx), 64'd5);
      check("bp total responses", 64'(got), 64'd5);
      if (idx == 5) begin
         check("bp first after release", 64'(acc_c[2]), 64'd0);
         check("bp one per cycle", 64'(acc_c[4] - acc_c[2]), 64'd2);
      end
      for (int i = 0; i < got; i++)
         check($sformatf("bp rsp%0d", i), 64'(rsp[i]), 64'(bx[i]));
      tick();
      @(negedge CLK);
      check("bp no extra response", 64'(rd_rsp_valid), 64'd0);
      tick();

      // Reset with two responses buffered.
      rd_rsp_ready = 1'b0;
      idx = 0;
      for (int k = 0; k < 5; k++) begin
         rd_req_valid = (idx < 2);
         rd_req_addr  = ba[(idx < 2) ? idx : 0];
         @(negedge CLK);
         if (rd_req_valid && rd_req_ready) idx++;
         tick();
      end
      rd_req_valid = 1'b0;
      @(negedge CLK);
      check("rst pre buffered", 64'(rd_rsp_valid), 64'd1);
      check("rst pre head", 64'(rd_rsp_data), 64'h00AD_00EF);
      tick();
      RST = 1'b1;
      @(negedge CLK);
      check("rst cycle outputs",
            64'({wr_ready, rd_req_ready, rd_rsp_valid, init_done,
                 mem_ce0, mem_ce1, mem_we0}), 64'd0);
      tick();
      RST = 1'b0;
      @(negedge CLK);
      check("rst after rsp_valid", 64'(rd_rsp_valid), 64'd0);
      check("rst reinit first write",
            64'({mem_we0, mem_a0}), 64'({1'b1, 9'h000}));
      for (c = 1; c <= 600; c++) begin
         if (c > 1) @(negedge CLK);
         if (init_done) break;
         tick();
      end
      check("reinit done cycle", 64'(c), 64'd513);
      check("reinit no stale rsp", 64'(rd_rsp_valid), 64'd0);
      tick();
      rd_rsp_ready = 1'b1;
      do_read(9'h1A3, 32'h0, "reinit 1A3");
      do_read(9'h005, 32'h0, "reinit 005");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
